mem_wb_stage: RTL and testbench

MEM/WB pipeline register for the five-stage pipelined CPU. It sits directly downstream of the data memory. Each cycle it captures the MEM-stage result: the ALU result, the raw word read from data memory, or PC+8. It applies load byte/halfword selection and sign or zero extension, and presents one registered write-back record to the register file and the forwarding unit. It also flags misaligned loads and counts retired instructions.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/load_ext.sv | 55 +++++
 rtl/mem_wb_stage.sv | 97 +++++++++
 tb/tb_mem_wb_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared constants, encodings and record types for the CPU pipeline
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int WB_SEL_W  = 2;
  localparam int LD_TYPE_W = 3;

  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd0;
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd1;
  localparam logic [WB_SEL_W-1:0] WB_PC8 = 2'd2;

  localparam logic [LD_TYPE_W-1:0] LD_W  = 3'd0;
  localparam logic [LD_TYPE_W-1:0] LD_H  = 3'd1;
  localparam logic [LD_TYPE_W-1:0] LD_HU = 3'd2;
  localparam logic [LD_TYPE_W-1:0] LD_B  = 3'd3;
  localparam logic [LD_TYPE_W-1:0] LD_BU = 3'd4;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic              reg_we;
    logic [XLEN-1:0]   wdata;
    logic              misaligned;
  } wb_rec_t;

endpackage

`default_nettype wire

// File: rtl/load_ext.sv
// ============================================================================
// load_ext : byte/halfword lane select with sign/zero extension and alignment check
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_ext
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0]      rdata,
  input  logic [1:0]           addr_lo,
  input  logic [LD_TYPE_W-1:0] ld_type,
  output logic [XLEN-1:0]      data,
  output logic                 misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unused encodings 5..7 fall into the word-load arm.
  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (ld_type)
      LD_H: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      LD_HU: begin
        data       = {16'h0000, half_sel};
        misaligned = addr_lo[0];
      end
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'h00_0000, byte_sel};
      default: begin
        data       = rdata;
        misaligned = (addr_lo != 2'd0);
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : MEM/WB pipeline register with load extension and retire counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_3000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 m_valid,
  input  logic [XLEN-1:0]      m_pc,
  input  logic [XLEN-1:0]      m_alu,
  input  logic [XLEN-1:0]      m_dm_rdata,
  input  logic [WB_SEL_W-1:0]  m_wb_sel,
  input  logic [LD_TYPE_W-1:0] m_ld_type,
  input  logic [REG_AW-1:0]    m_rd,
  input  logic                 m_reg_we,
  output logic                 w_valid,
  output logic [XLEN-1:0]      w_pc,
  output logic [REG_AW-1:0]    w_rd,
  output logic                 w_reg_we,
  output logic [XLEN-1:0]      w_wdata,
  output logic                 w_misaligned,
  output logic [XLEN-1:0]      w_retired
);

  logic [XLEN-1:0] ld_data;
  logic            ld_mis;
  wb_rec_t         mem_rec;
  wb_rec_t         rec_d, rec_q;
  logic [XLEN-1:0] retired_d, retired_q;

  load_ext u_load_ext (
    .rdata      (m_dm_rdata),
    .addr_lo    (m_alu[1:0]),
    .ld_type    (m_ld_type),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  // Record the M stage would hand over if this edge captures.
  always_comb begin
    mem_rec.valid      = m_valid;
    mem_rec.pc         = m_pc;
    mem_rec.rd         = m_rd;
    mem_rec.misaligned = (m_wb_sel == WB_MEM) && ld_mis;
    mem_rec.reg_we     = m_valid && m_reg_we && (m_rd != '0) && !mem_rec.misaligned;
    case (m_wb_sel)
      WB_MEM:  mem_rec.wdata = ld_data;
      WB_PC8:  mem_rec.wdata = m_pc + 32'd8;
      default: mem_rec.wdata = m_alu;
    endcase
  end

  always_comb begin
    rec_d     = rec_q;
    retired_d = retired_q;
    if (flush) begin
      rec_d.valid      = 1'b0;
      rec_d.rd         = '0;
      rec_d.reg_we     = 1'b0;
      rec_d.wdata      = '0;
      rec_d.misaligned = 1'b0;
    end else if (!stall) begin
      rec_d     = mem_rec;
      retired_d = retired_q + XLEN'(m_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_q     <= '{valid: 1'b0, pc: PC_RESET, rd: '0, reg_we: 1'b0,
                     wdata: '0, misaligned: 1'b0};
      retired_q <= '0;
    end else begin
      rec_q     <= rec_d;
      retired_q <= retired_d;
    end
  end

  assign w_valid      = rec_q.valid;
  assign w_pc         = rec_q.pc;
  assign w_rd         = rec_q.rd;
  assign w_reg_we     = rec_q.reg_we;
  assign w_wdata      = rec_q.wdata;
  assign w_misaligned = rec_q.misaligned;
  assign w_retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage : directed + random checks of mem_wb_stage against a reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        m_valid;
  logic [31:0] m_pc, m_alu, m_dm_rdata;
  logic [1:0]  m_wb_sel;
  logic [2:0]  m_ld_type;
  logic [4:0]  m_rd;
  logic        m_reg_we;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [4:0]  w_rd;
  logic        w_reg_we;
  logic [31:0] w_wdata;
  logic        w_misaligned;
  logic [31:0] w_retired;

  int n_vec = 0;
  int n_err = 0;

  // Expected W-stage state
  logic        e_valid, e_we, e_mis;
  logic [31:0] e_pc, e_wdata, e_ret;
  logic [4:0]  e_rd;

  always #5 clk = ~clk;

  mem_wb_stage #(.PC_RESET(32'h0000_3000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_pc         (m_pc),
    .m_alu        (m_alu),
    .m_dm_rdata   (m_dm_rdata),
    .m_wb_sel     (m_wb_sel),
    .m_ld_type    (m_ld_type),
    .m_rd         (m_rd),
    .m_reg_we     (m_reg_we),
    .w_valid      (w_valid),
    .w_pc         (w_pc),
    .w_rd         (w_rd),
    .w_reg_we     (w_reg_we),
    .w_wdata      (w_wdata),
    .w_misaligned (w_misaligned),
    .w_retired    (w_retired)
  );

  // Loaded value from the architectural rules: pick lane by shifting, then extend.
  function automatic logic [31:0] load_value(input logic [31:0] word, input int a, input int t);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((word >> (8 * a)) & 32'hFF);
    h = 16'((word >> (16 * (a / 2))) & 32'hFFFF);
    case (t)
      1: return 32'($signed(h));
      2: return 32'(h);
      3: return 32'($signed(b));
      4: return 32'(b);
      default: return word;
    endcase
  endfunction

  function automatic logic is_misaligned(input int a, input int t);
    if (t == 1 || t == 2) return (a % 2) != 0;
    if (t == 3 || t == 4) return 1'b0;
    return a != 0;
  endfunction

  task automatic model_edge();
    logic mis;
    if (reset) begin
      e_valid = 0; e_pc = 32'h0000_3000; e_rd = 0; e_we = 0;
      e_wdata = 0; e_mis = 0; e_ret = 0;
    end else if (flush) begin
      e_valid = 0; e_rd = 0; e_we = 0; e_wdata = 0; e_mis = 0;
    end else if (!stall) begin
      mis     = (m_wb_sel == 2'd1) && is_misaligned(int'(m_alu % 4), int'(m_ld_type));
      e_valid = m_valid;
      e_pc    = m_pc;
      e_rd    = m_rd;
      e_mis   = mis;
      e_we    = m_valid && m_reg_we && (m_rd != 0) && !mis;
      if (m_wb_sel == 2'd1)      e_wdata = load_value(m_dm_rdata, int'(m_alu % 4), int'(m_ld_type));
      else if (m_wb_sel == 2'd2) e_wdata = m_pc + 32'd8;
      else                       e_wdata = m_alu;
      if (m_valid) e_ret = e_ret + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   32'(w_valid),      32'(e_valid));
    chk({tag, ".pc"},      w_pc,              e_pc);
    chk({tag, ".rd"},      32'(w_rd),         32'(e_rd));
    chk({tag, ".reg_we"},  32'(w_reg_we),     32'(e_we));
    chk({tag, ".wdata"},   w_wdata,           e_wdata);
    chk({tag, ".mis"},     32'(w_misaligned), 32'(e_mis));
    chk({tag, ".retired"}, w_retired,         e_ret);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_m(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [1:0] sel,
                       input logic [2:0] ld, input logic [4:0] rd, input logic we);
    m_valid = v; m_pc = pc; m_alu = alu; m_dm_rdata = rdata;
    m_wb_sel = sel; m_ld_type = ld; m_rd = rd; m_reg_we = we;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    set_m(0, 0, 0, 0, 0, 0, 0, 0);
    e_valid = 0; e_pc = 0; e_rd = 0; e_we = 0; e_wdata = 0; e_mis = 0; e_ret = 0;

    tick();
    check_all("reset");
    chk("reset.pc_lit", w_pc, 32'h0000_3000);
    reset = 0;

    set_m(1, 32'h3000, 32'h0, 32'h8077_66F0, 2'd1, 3'd3, 5'd5, 1);
    tick();
    check_all("lb");
    chk("lb.wdata_lit", w_wdata, 32'hFFFF_FFF0);
    chk("lb.retired_lit", w_retired, 32'd1);

    set_m(1, 32'h3004, 32'h2, 32'h8077_66F0, 2'd1, 3'd2, 5'd6, 1);
    tick();
    check_all("lhu");
    chk("lhu.wdata_lit", w_wdata, 32'h0000_8077);

    m_ld_type = 3'd1;
    tick();
    check_all("lh");
    chk("lh.wdata_lit", w_wdata, 32'hFFFF_8077);

    m_alu = 32'h3; m_ld_type = 3'd4;
    tick();
    check_all("lbu3");
    chk("lbu3.wdata_lit", w_wdata, 32'h0000_0080);

    set_m(1, 32'h3010, 32'h6, 32'h1234_5678, 2'd1, 3'd0, 5'd7, 1);
    tick();
    check_all("lw_mis");
    chk("lw_mis.flag_lit", 32'(w_misaligned), 32'd1);
    chk("lw_mis.we_lit", 32'(w_reg_we), 32'd0);

    set_m(1, 32'h3014, 32'hDEAD_BEEF, 32'h0, 2'd0, 3'd0, 5'd0, 1);
    tick();
    check_all("rd0");
    chk("rd0.wdata_lit", w_wdata, 32'hDEAD_BEEF);

    set_m(1, 32'h3010, 32'h0, 32'h0, 2'd2, 3'd0, 5'd31, 1);
    tick();
    check_all("jal");
    chk("jal.wdata_lit", w_wdata, 32'h0000_3018);

    m_pc = 32'hFFFF_FFFC;
    tick();
    check_all("jal_wrap");
    chk("jal_wrap.wdata_lit", w_wdata, 32'h0000_0004);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_m(1, 32'h4000 + 32'(i * 4), 32'h55 + 32'(i), 32'hA5A5_A5A5, 2'(i % 3), 3'd0, 5'(i + 1), 1);
      tick();
      check_all("stall");
    end

    flush = 1;
    tick();
    check_all("stall_flush");
    chk("stall_flush.pc_lit", w_pc, 32'hFFFF_FFFC);
    stall = 0; flush = 0;

    for (int i = 0; i < 10; i++) begin
      set_m(1, 32'h5000 + 32'(i * 4), 32'(i), 32'h0, 2'd0, 3'd0, 5'd3, 1);
      tick();
    end
    check_all("ten_more");
    reset = 1;
    tick();
    check_all("mid_reset");
    chk("mid_reset.retired_lit", w_retired, 32'd0);
    reset = 0;
    set_m(1, 32'h6000, 32'h1, 32'h0, 2'd0, 3'd0, 5'd4, 1);
    tick();
    check_all("post_reset");
    chk("post_reset.retired_lit", w_retired, 32'd1);

    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      set_m(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
            2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
      tick();
      check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
